// File: rtl/bongo_envelope.sv
// bongo_envelope: hit-triggered amplitude envelope (attack to PEAK, then linear decay to idle)
// Ports: clk; rst (async, active-low); bongo_hit[1:0] sensor code (01 left, 10 right, 11 as left)
//        note_on one-cycle strobe per accepted hit; drum_sel last accepted drum (1 = right)
//        amplitude[7:0] envelope level; active high while not idle
// Build option: BONGO_RETRIGGER_EN lets a hit during ATTACK/DECAY restart the envelope
module bongo_envelope #(
    parameter int unsigned DECAY_DIV = 1000,
    parameter logic [7:0]  PEAK      = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bongo_hit,
    output logic       note_on,
    output logic       drum_sel,
    output logic [7:0] amplitude,
    output logic       active
);
    typedef enum logic [1:0] {IDLE, ATTACK, DECAY} state_t;
    localparam logic [15:0] DIV_M1 = 16'(DECAY_DIV - 1);
    state_t      state_q, state_d;
    logic [1:0]  hit_q, hit_d, code;
    logic [15:0] presc_q, presc_d;
    logic        note_q, note_d, drum_q, drum_d, act_q, act_d, hit_evt, accept;
    logic [7:0]  amp_q, amp_d;
    always_comb begin
        code    = (bongo_hit == 2'b11) ? 2'b01 : bongo_hit;
        hit_d   = code;
        hit_evt = (code != 2'b00) && (code != hit_q);
`ifdef BONGO_RETRIGGER_EN
        accept  = hit_evt;
`else
        accept  = hit_evt && (state_q == IDLE);
`endif
        state_d = state_q;
        presc_d = presc_q;
        note_d  = 1'b0;
        drum_d  = drum_q;
        amp_d   = amp_q;
        act_d   = act_q;
        if (accept) begin
            state_d = ATTACK;
            note_d  = 1'b1;
            drum_d  = code[1];
            amp_d   = PEAK;
            act_d   = 1'b1;
            presc_d = '0;
        end else if (state_q == ATTACK) begin
            state_d = DECAY;
            presc_d = '0;
        end else if (state_q == DECAY) begin
            presc_d = (presc_q == DIV_M1) ? 16'd0 : presc_q + 16'd1;
            if (presc_q == DIV_M1) begin
                amp_d = amp_q - 8'd1;
                // last step down lands in IDLE on the same edge
                if (amp_q == 8'd1) begin
                    state_d = IDLE;
                    act_d   = 1'b0;
                end
            end
        end else begin
            amp_d = '0;
            act_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hit_q   <= '0;
            presc_q <= '0;
            note_q  <= 1'b0;
            drum_q  <= 1'b0;
            amp_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            presc_q <= presc_d;
            note_q  <= note_d;
            drum_q  <= drum_d;
            amp_q   <= amp_d;
            act_q   <= act_d;
        end
    end
    assign note_on   = note_q;
    assign drum_sel  = drum_q;
    assign amplitude = amp_q;
    assign active    = act_q;
endmodule

// File: tb/tb_bongo_envelope.sv
// tb_bongo_envelope: randomized and directed checks of bongo_envelope against a time-since-hit model
module tb_bongo_envelope;
    localparam int DIV = 4;
    localparam int PK  = 16;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] bongo_hit = 2'b00;
    logic       note_on, drum_sel, active;
    logic [7:0] amplitude;
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t_hit = 0;
    bit has = 0;
    logic [1:0] prev = 2'b00;
    bit e_drum = 0;
    int e_amp = 0;
    int notes;
    bongo_envelope #(.DECAY_DIV(DIV), .PEAK(8'(PK))) dut (
        .clk(clk), .rst(rst), .bongo_hit(bongo_hit),
        .note_on(note_on), .drum_sel(drum_sel), .amplitude(amplitude), .active(active)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask
    // envelope level as a function of cycles elapsed since the accepted hit
    function automatic int amp_of(input int age);
        int a;
        if (age == 0) return PK;
        a = PK - (age - 1) / DIV;
        return (a < 0) ? 0 : a;
    endfunction
    task automatic tick(input logic [1:0] h);
        logic [1:0] hn;
        bit evt, acc;
        bongo_hit = h;
        @(posedge clk);
        #1;
        hn   = (h == 2'b11) ? 2'b01 : h;
        evt  = (hn != 2'b00) && (hn != prev);
        prev = hn;
`ifdef BONGO_RETRIGGER_EN
        acc = evt;
`else
        acc = evt && (e_amp == 0);
`endif
        cyc++;
        if (acc) begin
            has    = 1;
            t_hit  = cyc;
            e_drum = hn[1];
        end
        e_amp = has ? amp_of(cyc - t_hit) : 0;
        check("amplitude", 32'(amplitude), 32'(e_amp));
        check("note_on", 32'(note_on), 32'(has && cyc == t_hit));
        check("drum_sel", 32'(drum_sel), 32'(e_drum));
        check("active", 32'(active), 32'(e_amp != 0));
    endtask
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_amp", 32'(amplitude), 0);
        check("rst_note", 32'(note_on), 0);
        check("rst_drum", 32'(drum_sel), 0);
        check("rst_active", 32'(active), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        has = 0; prev = 2'b00; e_amp = 0; e_drum = 0;
    endtask
    initial begin
        logic [1:0] cur, nxt;
        int hold;
        bit hit9;
        repeat (3) @(posedge clk);
        #1;
        check("init_amp", 32'(amplitude), 0);
        check("init_note", 32'(note_on), 0);
        check("init_drum", 32'(drum_sel), 0);
        check("init_active", 32'(active), 0);
        @(negedge clk) rst = 1'b1;
        // single left hit, full decay while held
        tick(2'b01);
        check("first_note", 32'(note_on), 1);
        check("first_amp", 32'(amplitude), PK);
        for (int i = 1; i <= 65; i++) begin
            tick(2'b01);
            if (i == 64) check("active_before_end", 32'(active), 1);
        end
        check("active_at_end", 32'(active), 0);
        check("amp_at_end", 32'(amplitude), 0);
        // held right hit yields one note
        tick(2'b00);
        notes = 0;
        for (int i = 0; i < 200; i++) begin
            tick(2'b10);
            notes += int'(note_on);
        end
        check("held_notes", 32'(notes), 1);
        check("held_drum", 32'(drum_sel), 1);
        // switch drums mid-decay at amplitude 9
        tick(2'b00);
        tick(2'b01);
        hit9 = 0;
        for (int i = 0; i < 200 && !hit9; i++) begin
            tick(2'b01);
            hit9 = (amplitude == 8'd9);
        end
        check("reached_9", 32'(hit9), 1);
        tick(2'b10);
`ifdef BONGO_RETRIGGER_EN
        check("retrig_amp", 32'(amplitude), PK);
        check("retrig_note", 32'(note_on), 1);
`else
        check("noretrig_note", 32'(note_on), 0);
`endif
        repeat (8) tick(2'b10);
        // async reset mid-decay with hit held through release
        tick(2'b00);
        tick(2'b01);
        repeat (10) tick(2'b01);
        do_reset();
        tick(2'b01);
        check("post_rst_note", 32'(note_on), 1);
        repeat (70) tick(2'b01);
        // code 11 acts as left
        tick(2'b00);
        notes = 0;
        for (int i = 0; i < 5; i++) begin
            tick(2'b11);
            notes += int'(note_on);
        end
        check("both_notes", 32'(notes), 1);
        check("both_drum", 32'(drum_sel), 0);
        // random traffic
        cur = 2'b11;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                nxt = 2'($urandom_range(0, 3));
                if ((cur == 2'b01 && nxt == 2'b11) || (cur == 2'b11 && nxt == 2'b01)) nxt = 2'b00;
                cur  = nxt;
                hold = $urandom_range(1, 40);
            end
            hold--;
            tick(cur);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
